pps_interval_meter: RTL



---
 rtl/pps_interval_meter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pps_interval_meter.sv
// Start/stop interval meter: counts cnt_en ticks from an in_a rising edge to the next in_b rising edge.
// Results are read byte-wise through a coherent shadow. Define PPS_METER_AVG_EN to publish the mean of four measurements.
module pps_interval_meter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 5_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt_en,
  input  logic       in_a,
  input  logic       in_b,
  input  logic [3:0] rd_strobe,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       valid,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_COUNT = 1'b1
  } state_t;

  // Input conditioning: two synchronizer flops, a history flop, and a registered rising-edge pulse.
  logic [1:0] a_sync_q;
  logic [1:0] b_sync_q;
  logic       a_prev_q;
  logic       b_prev_q;
  logic       sa_q;
  logic       sb_q;
  logic       sa_d;
  logic       sb_d;

  assign sa_d = a_sync_q[1] & ~a_prev_q;
  assign sb_d = b_sync_q[1] & ~b_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      a_prev_q <= 1'b0;
      b_prev_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[0], in_a};
      b_sync_q <= {b_sync_q[0], in_b};
      a_prev_q <= a_sync_q[1];
      b_prev_q <= b_sync_q[1];
      sa_q     <= sa_d;
      sb_q     <= sb_d;
    end
  end

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             latch;
  logic [CNT_W-1:0] latch_val;
  logic             to_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // In COUNT a stop pulse latches the count before this cycle's tick; a simultaneous start then restarts.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch     = 1'b0;
    latch_val = '0;
    to_evt    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sa_q && sb_q) begin
          latch = 1'b1;
        end else if (sa_q) begin
          state_d = S_COUNT;
          cnt_d   = '0;
        end
      end
      S_COUNT: begin
        if (cnt_q >= TMO) begin
          to_evt  = 1'b1;
          state_d = S_IDLE;
        end else begin
          if (cnt_en) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (sb_q) begin
            latch     = 1'b1;
            latch_val = cnt_q;
            state_d   = S_IDLE;
          end
          if (sa_q) begin
            cnt_d   = '0;
            state_d = S_COUNT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic             pub;
  logic [CNT_W-1:0] pub_val;
  logic             pub_to;

`ifdef PPS_METER_AVG_EN
  logic [CNT_W+1:0] acc_q;
  logic [CNT_W+1:0] acc_d;
  logic [CNT_W+1:0] acc_sum;
  logic [1:0]       acc_n_q;
  logic [1:0]       acc_n_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      acc_n_q <= '0;
    end else begin
      acc_q   <= acc_d;
      acc_n_q <= acc_n_d;
    end
  end

  always_comb begin
    acc_d   = acc_q;
    acc_n_d = acc_n_q;
    pub     = 1'b0;
    pub_val = '0;
    pub_to  = 1'b0;
    acc_sum = acc_q + {2'b00, latch_val};
    if (to_evt) begin
      acc_d   = '0;
      acc_n_d = '0;
      pub     = 1'b1;
      pub_val = '1;
      pub_to  = 1'b1;
    end else if (latch) begin
      if (acc_n_q == 2'd3) begin
        pub     = 1'b1;
        pub_val = acc_sum[CNT_W+1:2];
        acc_d   = '0;
        acc_n_d = '0;
      end else begin
        acc_d   = acc_sum;
        acc_n_d = acc_n_q + 2'd1;
      end
    end
  end
`else
  always_comb begin
    pub     = to_evt | latch;
    pub_val = to_evt ? '1 : latch_val;
    pub_to  = to_evt;
  end
`endif

  logic [CNT_W-1:0] result_q;
  logic [CNT_W-1:0] result_d;
  logic [CNT_W-1:0] shadow_q;
  logic [CNT_W-1:0] shadow_d;
  logic             valid_q;
  logic             valid_d;
  logic             timeout_q;
  logic             timeout_d;
  logic             data_oe_q;
  logic             data_oe_d;
  logic [7:0]       data_out_q;
  logic [7:0]       data_out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= '0;
      shadow_q   <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      data_oe_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      result_q   <= result_d;
      shadow_q   <= shadow_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      data_oe_q  <= data_oe_d;
      data_out_q <= data_out_d;
    end
  end

  // Byte 0 snapshots the result so bytes 1..3 stay coherent; a publish overrides a byte-3 flag clear.
  always_comb begin
    result_d   = result_q;
    shadow_d   = shadow_q;
    valid_d    = valid_q;
    timeout_d  = timeout_q;
    data_oe_d  = 1'b0;
    data_out_d = '0;
    case (rd_strobe)
      4'b0001: begin
        shadow_d   = result_q;
        data_oe_d  = 1'b1;
        data_out_d = result_q[7:0];
      end
      4'b0010: begin
        data_oe_d  = 1'b1;
        data_out_d = shadow_q[15:8];
      end
      4'b0100: begin
        data_oe_d  = 1'b1;
        data_out_d = shadow_q[23:16];
      end
      4'b1000: begin
        data_oe_d  = 1'b1;
        data_out_d = shadow_q[31:24];
        valid_d    = 1'b0;
        timeout_d  = 1'b0;
      end
      default: begin
        data_oe_d = 1'b0;
      end
    endcase
    if (pub) begin
      result_d  = pub_val;
      valid_d   = 1'b1;
      timeout_d = pub_to;
    end
  end

  assign data_out = data_out_q;
  assign data_oe  = data_oe_q;
  assign valid    = valid_q;
  assign timeout  = timeout_q;

endmodule
